// File: rtl/snn_pkg.sv
// Shared SNN constants and the encoder state type, used by the spike encoder
// and the spike-counting output layer.
package snn_pkg;

  localparam int unsigned DEF_INPUT_SIZE  = 16;
  localparam int unsigned DEF_PIXEL_WIDTH = 8;
  localparam int unsigned DEF_NUM_STEPS   = 32;
  localparam logic [15:0] DEF_LFSR_SEED   = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } enc_state_t;

endpackage

// File: rtl/spike_lane.sv
// One encoder channel: latched pixel, sigma-delta accumulator (or LFSR
// comparator when SPIKE_ENC_LFSR_EN is defined) and the registered spike bit.
module spike_lane
  import snn_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   run,
  input  logic [PIXEL_WIDTH-1:0] pixel,
`ifdef SPIKE_ENC_LFSR_EN
  input  logic [PIXEL_WIDTH-1:0] rnd,
`endif
  output logic                   spike
);

  logic [PIXEL_WIDTH-1:0] pix_reg;

`ifdef SPIKE_ENC_LFSR_EN

  // Latch pixel on accept; per step spike when the pixel beats the random draw.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_reg <= '0;
      spike   <= 1'b0;
    end else if (load) begin
      pix_reg <= pixel;
      spike   <= 1'b0;
    end else if (run) begin
      spike   <= (pix_reg > rnd);
    end else begin
      spike   <= 1'b0;
    end
  end

`else

  logic [PIXEL_WIDTH-1:0] acc;
  logic [PIXEL_WIDTH:0]   sum;

  // Accumulator plus pixel; the carry out is the spike.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, pix_reg};
  end

  // Latch pixel and clear accumulator on accept; integrate each RUN step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_reg <= '0;
      acc     <= '0;
      spike   <= 1'b0;
    end else if (load) begin
      pix_reg <= pixel;
      acc     <= '0;
      spike   <= 1'b0;
    end else if (run) begin
      spike   <= sum[PIXEL_WIDTH];
      acc     <= sum[PIXEL_WIDTH-1:0];
    end else begin
      spike   <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding input layer: accepts a pixel frame, emits NUM_STEPS spike
// vectors, then drains for one cycle. Define SPIKE_ENC_LFSR_EN for
// stochastic (LFSR) coding instead of the default sigma-delta coding.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int unsigned INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int unsigned NUM_STEPS   = DEF_NUM_STEPS,
  parameter int unsigned STEP_WIDTH  = $clog2(NUM_STEPS),
  parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUT_SIZE*PIXEL_WIDTH-1:0] pixel_in,
  input  logic                              pixel_valid,
  output logic                              pixel_ready,
  input  logic                              abort,
  output logic [INPUT_SIZE-1:0]             spike,
  output logic                              out_valid,
  output logic [STEP_WIDTH-1:0]             step_idx,
  output logic                              frame_done
);

  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(NUM_STEPS - 1);

  enc_state_t            state, state_nxt;
  logic                  load, run;
  logic [STEP_WIDTH-1:0] cnt;

  // Next-state decode; abort in RUN returns straight to IDLE with no drain.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    run         = 1'b0;
    pixel_ready = 1'b0;
    case (state)
      IDLE: begin
        pixel_ready = 1'b1;
        if (pixel_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          run = 1'b1;
          if (cnt == LAST_STEP) state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Step counter and registered framing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      out_valid  <= 1'b0;
      step_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN);
      if (load) cnt <= '0;
      if (run) begin
        out_valid <= 1'b1;
        step_idx  <= cnt;
        if (cnt != LAST_STEP) cnt <= cnt + 1'b1;
      end else begin
        out_valid <= 1'b0;
        step_idx  <= '0;
      end
    end
  end

`ifdef SPIKE_ENC_LFSR_EN
  logic [15:0] lfsr;

  // Galois LFSR (taps 16,14,13,11), advancing once per RUN cycle, never reseeded per frame.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else if (state == RUN) lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
  end
`endif

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_lane
`ifdef SPIKE_ENC_LFSR_EN
    localparam int unsigned ROT = i % 16;
    logic [15:0] rot;
    // Each lane sees the LFSR rotated left by its index to decorrelate lanes.
    if (ROT == 0) begin : g_norot
      assign rot = lfsr;
    end else begin : g_rot
      assign rot = {lfsr[15-ROT:0], lfsr[15:16-ROT]};
    end
`endif
    spike_lane #(
      .PIXEL_WIDTH(PIXEL_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .run  (run),
      .pixel(pixel_in[i*PIXEL_WIDTH +: PIXEL_WIDTH]),
`ifdef SPIKE_ENC_LFSR_EN
      .rnd  (rot[PIXEL_WIDTH-1:0]),
`endif
      .spike(spike[i])
    );
  end

endmodule
